// File: rtl/parity_frame_tx.sv
// Serial frame transmitter fed by the 9-bit parity generator.
// Frame on tx: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// The incoming parity bit is sent unchanged. It is also checked against a
// locally recomputed parity, and any disagreement is reported on par_mismatch.
module parity_frame_tx #(
  parameter int DATA_W       = 9,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              par_mismatch
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] TMR_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic          ODD_BIT  = (ODD_PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic              par_bit, par_nxt;
  logic [CW-1:0]     tmr, tmr_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic              mismatch_nxt;
  logic              tx_nxt;
  logic              accept;
  logic              tmr_wrap;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign tmr_wrap = (tmr == TMR_LAST);

  // Next-state logic: the bit-time timer paces every state except IDLE.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave one unassigned and infer a latch; combinational blocks use '='.
    state_nxt    = state;
    shift_nxt    = shift_reg;
    par_nxt      = par_bit;
    tmr_nxt      = tmr;
    bit_cnt_nxt  = bit_cnt;
    mismatch_nxt = par_mismatch;
    if (state != S_IDLE) begin
      tmr_nxt = tmr_wrap ? '0 : tmr + CW'(1);
    end
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt    = S_START;
          shift_nxt    = in_data;
          par_nxt      = in_par;
          tmr_nxt      = '0;
          bit_cnt_nxt  = '0;
          mismatch_nxt = in_par ^ (^in_data) ^ ODD_BIT;
        end
      end
      S_START: begin
        if (tmr_wrap) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (tmr_wrap) begin
          shift_nxt   = shift_reg >> 1;
          bit_cnt_nxt = bit_cnt + BW'(1);
          if (bit_cnt == BIT_LAST) begin
            state_nxt = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (tmr_wrap) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr_wrap) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Line level for the coming cycle, decoded from the next state so that tx can be a flop.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and registered outputs; a low rst_n aborts any frame in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses '<=' so all flops update from pre-edge values.
    if (!rst_n) begin
      state        <= S_IDLE;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      tmr          <= '0;
      bit_cnt      <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      par_mismatch <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift_reg    <= shift_nxt;
      par_bit      <= par_nxt;
      tmr          <= tmr_nxt;
      bit_cnt      <= bit_cnt_nxt;
      tx           <= tx_nxt;
      busy         <= (state_nxt != S_IDLE);
      frame_done   <= (state_nxt == S_STOP) && (tmr_nxt == TMR_LAST);
      par_mismatch <= mismatch_nxt;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx.
// A driver pushes expected frames into a queue at acceptance. A monitor pops
// one frame whenever busy rises and checks the whole frame cycle by cycle.
// A second instance with CLKS_PER_BIT=1 and ODD_PARITY=1 is checked directly.
module tb_parity_frame_tx;

  localparam int DW   = 9;
  localparam int CPB  = 4;
  localparam int FL   = DW + 3;
  localparam int CPB1 = 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    logic          mm;
    int            acc_cyc;
    bit            b2b;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_par = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, tx, busy, frame_done, par_mismatch;

  logic [DW-1:0] in_data1 = '0;
  logic          in_par1 = 1'b0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1, tx1, busy1, frame_done1, par_mismatch1;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  item_t exp_q[$];
  bit    aborting = 1'b1;
  bit    in_frame = 1'b0;

  parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_par(in_par),
    .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy),
    .frame_done(frame_done), .par_mismatch(par_mismatch)
  );

  parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB1), .ODD_PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_par(in_par1),
    .in_valid(in_valid1), .in_ready(in_ready1), .tx(tx1), .busy(busy1),
    .frame_done(frame_done1), .par_mismatch(par_mismatch1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line levels of a whole frame, index 0 is the first bit on the wire.
  function automatic logic [FL-1:0] ref_bits(input logic [DW-1:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Mismatch = received parity differs from the parity the word should carry.
  function automatic logic ref_mm(input logic [DW-1:0] d, input logic p, input bit odd);
    int  ones;
    logic want;
    ones = $countones(d);
    want = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return p != want;
  endfunction

  // Called at a negedge; offers a word, records it at acceptance, then either
  // keeps in_valid high (hold) or scribbles on the inputs while the frame runs.
  task automatic send_word(input logic [DW-1:0] d, input logic p, input bit hold, input bit b2b);
    int    n;
    item_t it;
    in_data  = d;
    in_par   = p;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    it.data    = d;
    it.par     = p;
    it.mm      = ref_mm(d, p, 1'b0);
    it.acc_cyc = cyc + 1;
    it.b2b     = b2b;
    exp_q.push_back(it);
    @(posedge clk);
    @(negedge clk);
    if (hold) return;
    n = 0;
    while (!in_ready && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom_range(0, 511));
      in_par   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
  endtask

  // Frame monitor for the CLKS_PER_BIT=4 instance.
  item_t         cur;
  logic [FL-1:0] cur_bits;
  int            mc;
  int            last_done = -10;
  logic          last_mm = 1'b0;

  initial begin : monitor
    mc = 0;
    forever begin
      @(negedge clk);
      if (aborting || !rst_n) begin
        in_frame = 1'b0;
        last_mm  = 1'b0;
      end else begin
        if (!in_frame) begin
          if (busy) begin
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'd1, 32'd0);
            end else begin
              cur      = exp_q.pop_front();
              cur_bits = ref_bits(cur.data, cur.par);
              in_frame = 1'b1;
              mc       = 0;
              check("start_latency", cyc, cur.acc_cyc);
              if (cur.b2b) check("b2b_gap", cyc, last_done + 2);
            end
          end else begin
            check("idle_tx", tx, 1);
            check("idle_done", frame_done, 0);
            check("idle_mm", par_mismatch, last_mm);
          end
        end
        if (in_frame) begin
          check($sformatf("tx_c%0d", mc), tx, cur_bits[mc / CPB]);
          check($sformatf("busy_c%0d", mc), busy, 1);
          check($sformatf("ready_c%0d", mc), in_ready, 0);
          check($sformatf("done_c%0d", mc), frame_done, (mc == FL * CPB - 1));
          check($sformatf("mm_c%0d", mc), par_mismatch, cur.mm);
          if (mc == FL * CPB - 1) begin
            in_frame  = 1'b0;
            last_done = cyc;
            last_mm   = cur.mm;
          end
          mc++;
        end
      end
    end
  end

  // Directed frame on the CLKS_PER_BIT=1, odd-parity instance.
  task automatic send1(input logic [DW-1:0] d, input logic p);
    logic [FL-1:0] b;
    logic          mm;
    int            n;
    b  = ref_bits(d, p);
    mm = ref_mm(d, p, 1'b1);
    in_data1  = d;
    in_par1   = p;
    in_valid1 = 1'b1;
    n = 0;
    while (!in_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("u1_ready", in_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = ~d;
    for (int c = 0; c < FL; c++) begin
      check($sformatf("u1_tx_c%0d", c), tx1, b[c]);
      check($sformatf("u1_done_c%0d", c), frame_done1, (c == FL - 1));
      check($sformatf("u1_mm_c%0d", c), par_mismatch1, mm);
      @(negedge clk);
    end
    check("u1_gap_busy", busy1, 0);
    check("u1_gap_tx", tx1, 1);
    check("u1_gap_ready", in_ready1, 1);
  endtask

  initial begin : driver
    bit prev_hold;
    bit hold;
    int n;
    item_t it;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_mm", par_mismatch, 0);
    check("rst_ready", in_ready, 1);
    check("rst_tx1", tx1, 1);
    rst_n = 1'b1;
    @(negedge clk);
    aborting = 1'b0;
    @(negedge clk);

    // Reference frame, then parity error, then a clean word clearing it.
    send_word(9'h0A5, 1'b0, 1'b0, 1'b0);
    send_word(9'h0A5, 1'b1, 1'b0, 1'b0);
    send_word(9'h001, 1'b1, 1'b0, 1'b0);

    // Two words queued behind a held in_valid.
    send_word(9'h13C, 1'b0, 1'b1, 1'b0);
    send_word(9'h0F0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with random back-to-back chaining and idle gaps.
    prev_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hold = (i != 19) && ($urandom_range(0, 2) == 0);
      send_word(DW'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), hold, prev_hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      prev_hold = hold;
    end

    // Wait for the last frame to drain.
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 200), 1);
    @(negedge clk);

    // Reset during data bit 4 aborts the frame.
    in_data  = 9'h1B6;
    in_par   = 1'b1;
    in_valid = 1'b1;
    it.data = 9'h1B6; it.par = 1'b1; it.mm = ref_mm(9'h1B6, 1'b1, 1'b0);
    it.acc_cyc = cyc + 1; it.b2b = 1'b0;
    exp_q.push_back(it);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (21) @(negedge clk);
    aborting = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    check("abort_mm", par_mismatch, 0);
    check("abort_done", frame_done, 0);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1) n++;
    end
    check("abort_no_done", n, 0);
    aborting = 1'b0;
    @(negedge clk);

    // Single-clock-per-bit, odd-parity instance.
    send1(9'h1FF, 1'b0);
    send1(9'h1FF, 1'b1);
    for (int i = 0; i < 4; i++) send1(DW'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
